// File: rtl/alu_exec_unit_pkg.sv
// Shared opcodes and state type for the execute-stage ALU.
// Define ALU_MUL_EN to include the iterative multiplier and its MUL state.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  // New code; decodes as ADD when the multiplier is not built in
  localparam logic [3:0] ALU_MUL = 4'b1000;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} alu_state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} alu_state_t;
`endif

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// Built only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             busy;
  logic [WIDTH-1:0] step;

  // The final step's sum is exposed directly so the product is ready with done
  assign step    = mplier[0] ? acc + mcand : acc;
  assign product = step;
  assign done    = busy && (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      count  <= CW'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count == '0) begin
        busy <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a registered result/zero flag.
// Define ALU_MUL_EN to add the iterative multiply (stalls the input side while busy).
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  alu_state_t       state;
  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] alu_out;

`ifdef ALU_MUL_EN
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_mul  = (operation == ALU_MUL);
  assign inReady = (state == IDLE) || ((state == DONE) && outReady);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (srcA),
    .b       (srcB),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul  = 1'b0;
  assign inReady = !outValid || outReady;
`endif

  assign accept = inValid && inReady;

  // Single-cycle datapath; unknown codes (and MUL without the multiplier) add
  always_comb begin
    alu_out = srcA + srcB;
    case (operation)
      ALU_AND: alu_out = srcA & srcB;
      ALU_OR:  alu_out = srcA | srcB;
      ALU_SUB: alu_out = srcA - srcB;
      ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: alu_out = srcA + srcB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      outValid <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_mul) begin
`ifdef ALU_MUL_EN
              state    <= MUL;
`endif
              outValid <= 1'b0;
            end else begin
              state    <= DONE;
              outValid <= 1'b1;
              result   <= alu_out;
              zero     <= (alu_out == '0);
            end
          end else if ((state == DONE) && outReady) begin
            state    <= IDLE;
            outValid <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          if (mul_done) begin
            state    <= DONE;
            outValid <= 1'b1;
            result   <= mul_product;
            zero     <= (mul_product == '0);
          end
        end
`endif
        default: begin
          state    <= IDLE;
          outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases plus randomized ops vs a reference model.
// Expected latency and MUL results follow ALU_MUL_EN.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             inValid;
  logic             inReady;
  logic [3:0]       operation;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             zero;

  int checks;
  int errors;
  int ready_mode;
  logic [WIDTH-1:0] exp_q[$];

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .inValid   (inValid),
    .inReady   (inReady),
    .operation (operation),
    .srcA      (srcA),
    .srcB      (srcB),
    .outValid  (outValid),
    .outReady  (outReady),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the arithmetic rules stated as plain math
  function automatic logic [WIDTH-1:0] model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    prod = '0;
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SUB: return a - b;
      ALU_SLT: return (sa < sb) ? 1 : 0;
`ifdef ALU_MUL_EN
      ALU_MUL: begin
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return prod[WIDTH-1:0];
      end
`endif
      default: return a + b;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one op and hold it until accepted; returns just after the accepting edge
  task automatic apply_stimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    inValid   = 1'b1;
    operation = op;
    srcA      = a;
    srcB      = b;
    #1;
    while (!inReady && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!inReady) begin
      check_output("accept_timeout", 32'd0, 32'd1);
      inValid = 1'b0;
      return;
    end
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Consumer readiness: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    outReady = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_mode == 0)      outReady = 1'b1;
      else if (ready_mode == 1) outReady = 1'b0;
      else                      outReady = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every drain and checks output hold under backpressure
  initial begin
    logic             prev_hold;
    logic [WIDTH-1:0] prev_result;
    logic [WIDTH-1:0] e;
    prev_hold   = 1'b0;
    prev_result = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check_output("hold_valid", {31'd0, outValid}, 32'd1);
          check_output("hold_result", result, prev_result);
        end
        if (outValid && outReady) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_output", result, 32'hDEAD_0000);
          end else begin
            e = exp_q.pop_front();
            check_output("sb_result", result, e);
            check_output("sb_zero", {31'd0, zero}, {31'd0, (e == '0)});
          end
        end
        prev_hold   = outValid && !outReady;
        prev_result = result;
      end
    end
  end

  initial begin
    logic [3:0] ops[8];
    int n;
    int waited;
    logic [3:0] op;
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL, 4'hF, 4'h3};
    checks     = 0;
    errors     = 0;
    ready_mode = 0;
    reset      = 1'b1;
    inValid    = 1'b0;
    operation  = ALU_ADD;
    srcA       = '0;
    srcB       = '0;
    #1;
    check_output("rst_outValid", {31'd0, outValid}, 32'd0);
    check_output("rst_result", result, 32'd0);
    check_output("rst_zero", {31'd0, zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset during multiply");
    ready_mode = 1;
    apply_stimulus(ALU_MUL, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_output("midrst_outValid", {31'd0, outValid}, 32'd0);
    check_output("midrst_result", result, 32'd0);
    check_output("midrst_zero", {31'd0, zero}, 32'd0);
    ready_mode = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("midrst_inReady", {31'd0, inReady}, 32'd1);

    $display("[TB] arithmetic corners");
    apply_stimulus(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    check_output("add_wrap_valid", {31'd0, outValid}, 32'd1);
    check_output("add_wrap_result", result, 32'd0);
    check_output("add_wrap_zero", {31'd0, zero}, 32'd1);
    apply_stimulus(ALU_SUB, 32'd5, 32'd7);
    check_output("sub_result", result, 32'hFFFF_FFFE);
    check_output("sub_zero", {31'd0, zero}, 32'd0);
    apply_stimulus(ALU_SLT, 32'h8000_0000, 32'd1);
    check_output("slt_neg", result, 32'd1);
    apply_stimulus(ALU_SLT, 32'd1, 32'h8000_0000);
    check_output("slt_pos", result, 32'd0);
    apply_stimulus(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
    check_output("and_result", result, 32'h0000_F000);

    $display("[TB] back-to-back");
    apply_stimulus(ALU_ADD, 32'd10, 32'd20);
    check_output("b2b_add", result, 32'd30);
    check_output("b2b_ready0", {31'd0, inReady}, 32'd1);
    apply_stimulus(ALU_OR, 32'h00F0, 32'h000F);
    check_output("b2b_or", result, 32'h00FF);
    check_output("b2b_ready1", {31'd0, inReady}, 32'd1);
    apply_stimulus(ALU_SUB, 32'd100, 32'd1);
    check_output("b2b_sub", result, 32'd99);
    check_output("b2b_valid", {31'd0, outValid}, 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;

    $display("[TB] backpressure");
    ready_mode = 1;
    apply_stimulus(ALU_ADD, 32'd2, 32'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inValid   = 1'b1;
      operation = ALU_ADD;
      srcA      = 32'd40;
      srcB      = 32'd2;
      #1;
      check_output("bp_inReady", {31'd0, inReady}, 32'd0);
      check_output("bp_result", result, 32'd5);
    end
    ready_mode = 0;
    apply_stimulus(ALU_ADD, 32'd40, 32'd2);
    check_output("bp_after_drain", result, 32'd42);

    $display("[TB] multiply latency");
    apply_stimulus(ALU_MUL, 32'h0001_0000, 32'h0001_0001);
    n = 1;
    while (!outValid && n < 100) begin
      check_output("mul_inReady", {31'd0, inReady}, 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
`ifdef ALU_MUL_EN
    check_output("mul_latency", n, 32'd33);
    check_output("mul_result", result, 32'h0001_0000);
`else
    check_output("mul_latency", n, 32'd1);
    check_output("mul_result", result, 32'h0002_0001);
`endif

    $display("[TB] random traffic");
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0: apply_stimulus(op, $urandom, $urandom);
        1: apply_stimulus(op, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)));
        2: apply_stimulus(op, 32'h8000_0000 ^ 32'($urandom_range(0, 3)), $urandom);
        default: apply_stimulus(op, $urandom, 32'h0);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    ready_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check_output("drain_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
